x_fifo_s8_s2: RTL
=================

X_FIFO_S8_S2 -- requirements
Module: x_fifo_s8_s2

Interface
REQ-001 SHALL have parameter ALMOST_FULL_OFFSET, default 12'd64: ALMOSTFULL asserts when free dibit slots <= this value.
REQ-002 SHALL have parameter ALMOST_EMPTY_OFFSET, default 12'd16: ALMOSTEMPTY asserts when stored dibits <= this value.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port DI  input  8  write byte.
REQ-006 SHALL have port WREN  input  1  write request.
REQ-007 SHALL have port FULL  output  1  fewer than 4 free dibit slots.
REQ-008 SHALL have port ALMOSTFULL  output  1  programmable full flag.
REQ-009 SHALL have port WRERR  output  1  one-cycle pulse, write rejected.
REQ-010 SHALL have port RDEN  input  1  read request.
REQ-011 SHALL have port DO  output  2  read dibit, registered.
REQ-012 SHALL have port DOVALID  output  1  DO holds a newly read dibit.
REQ-013 SHALL have port EMPTY  output  1  no stored dibits.
REQ-014 SHALL have port ALMOSTEMPTY  output  1  programmable empty flag.
REQ-015 SHALL have port RDERR  output  1  one-cycle pulse, read rejected.
REQ-016 SHALL have port COUNT  output  12  stored dibits, 0..2048.

Function
REQ-017 SHALL store 4096 bits: 512 bytes on the write side, seen as 2048 dibits on the read side.
REQ-018 SHALL use write pointer of 9 address bits plus 1 wrap bit, and read pointer of 11 address bits plus 1 wrap bit.
REQ-019 SHALL accept a write when WREN=1 and FULL=0: byte stored at wr_addr, wr_ptr+1; otherwise WREN=1 pulses WRERR next cycle.
REQ-020 SHALL accept a read when RDEN=1 and EMPTY=0: DO <= dibit at rd_addr next cycle, DOVALID=1 that cycle, rd_ptr+1; otherwise RDEN=1 pulses RDERR next cycle.
REQ-021 SHALL read dibit order DI[1:0] first, then DI[3:2], DI[5:4], DI[7:6] (dibit index = byte index*4 + k).
REQ-022 SHALL hold DO when no read is accepted; DOVALID=0 in that cycle.
REQ-023 SHALL compute occupancy = {wr_ptr,2'b00} - rd_ptr, modulo 4096, giving 0..2048 dibits.
REQ-024 SHALL derive flags from registered pointers: EMPTY = (occ==0); FULL = (occ>2044); ALMOSTFULL = (2048-occ <= ALMOST_FULL_OFFSET); ALMOSTEMPTY = (occ <= ALMOST_EMPTY_OFFSET).
REQ-025 SHALL update flags and COUNT in the cycle after the accepting edge, with no combinational path from WREN or RDEN.
REQ-026 SHALL allow a simultaneous accepted read and write: both pointers advance and occupancy changes by +3.
REQ-027 SHALL wrap both pointers at the end of the array without loss; the wrap bits distinguish full from empty.
REQ-028 SHALL never return write data combinationally: a read of a byte written in the same cycle is impossible by construction, because EMPTY/FULL gate access.

Reset
REQ-029 SHALL, on RST=1 at posedge CLK: pointers=0, DO=2'b00, DOVALID=0, EMPTY=1, ALMOSTEMPTY=1, FULL=0, ALMOSTFULL=0, WRERR=0, RDERR=0, COUNT=0.
REQ-030 SHALL give RST priority over WREN and RDEN in the same cycle; both requests are dropped with no error pulse.
REQ-031 SHALL leave memory contents unchanged on reset.

Configuration
REQ-032 SHALL, with X_FIFO_S8_S2_COUNT_EN defined, drive COUNT with occupancy and implement ALMOSTFULL/ALMOSTEMPTY per REQ-024.
REQ-033 SHALL, without X_FIFO_S8_S2_COUNT_EN, tie COUNT, ALMOSTFULL and ALMOSTEMPTY to 0; FULL and EMPTY are unchanged.

Structure
REQ-034 SHALL place constants in shared package x_fifo_pkg: MEM_BITS=4096, WR_W=8, RD_W=2, WR_AW=9, RD_AW=11, FULL_MARGIN=4.
REQ-035 SHALL implement storage as one sub-module x_fifo_s8_s2_mem: 8-bit synchronous write port and 2-bit registered read port, single clock.

Verification
REQ-036 SHALL check: reset, then write 8'hE4, read 4 times -> DO sequence 0,1,2,3 with DOVALID each cycle, then EMPTY=1.
REQ-037 SHALL check: 512 writes from empty -> FULL=1 after write 512; write 513 -> WRERR=1 for one cycle, data unchanged.
REQ-038 SHALL check: FULL, then 4 reads -> FULL=0 one cycle later, COUNT=2044 (COUNT_EN defined).
REQ-039 SHALL check: RDEN while EMPTY -> RDERR=1 for one cycle, DO held, DOVALID=0.
REQ-040 SHALL check: continuous simultaneous read and write across 3 pointer wraps -> data in order, COUNT advances +3 per cycle until FULL.
REQ-041 SHALL check: RST asserted mid-stream with WREN=RDEN=1 -> next cycle EMPTY=1, COUNT=0, DO=0, no error pulses.

Source files
------------

// File: rtl/x_fifo_pkg.sv
// Shared constants and helpers for the 8-bit-write / 2-bit-read FIFO.
package x_fifo_pkg;

    localparam int MEM_BITS    = 4096;
    localparam int WR_W        = 8;
    localparam int RD_W        = 2;
    localparam int WR_AW       = 9;
    localparam int RD_AW       = 11;
    localparam int FULL_MARGIN = 4;
    localparam int CNT_W       = RD_AW + 1;

    localparam logic [CNT_W-1:0] RD_DEPTH   = CNT_W'(MEM_BITS / RD_W);
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(MEM_BITS / RD_W - FULL_MARGIN);

    typedef logic [WR_AW:0] wr_ptr_t;
    typedef logic [RD_AW:0] rd_ptr_t;

    // Dibit k of a byte; k=0 is the least significant pair.
    function automatic logic [RD_W-1:0] dibit_sel(input logic [WR_W-1:0] b,
                                                  input logic [1:0]      k);
        return b[{k, 1'b0} +: RD_W];
    endfunction

endpackage

// File: rtl/x_fifo_s8_s2_mem.sv
// Byte-wide write, dibit-wide registered read storage array (single clock).
module x_fifo_s8_s2_mem
    import x_fifo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WR_AW-1:0] waddr,
    input  logic [WR_W-1:0]  wdata,
    input  logic             re,
    input  logic [RD_AW-1:0] raddr,
    output logic [RD_W-1:0]  rdata_p1
);

    logic [WR_W-1:0] mem [2**WR_AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read register stage: only the output register sees reset, the array never does.
    always_ff @(posedge clk) begin
        if (rst)
            rdata_p1 <= '0;
        else if (re)
            rdata_p1 <= dibit_sel(mem[raddr[RD_AW-1:2]], raddr[1:0]);
    end

endmodule

// File: rtl/x_fifo_s8_s2.sv
// 512x8 in / 2048x2 out synchronous FIFO. Optional COUNT and almost flags
// are built only when X_FIFO_S8_S2_COUNT_EN is defined.
module x_fifo_s8_s2
    import x_fifo_pkg::*;
#(
    parameter logic [11:0] ALMOST_FULL_OFFSET  = 12'd64,
    parameter logic [11:0] ALMOST_EMPTY_OFFSET = 12'd16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WR_W-1:0]  DI,
    input  logic             WREN,
    output logic             FULL,
    output logic             ALMOSTFULL,
    output logic             WRERR,
    input  logic             RDEN,
    output logic [RD_W-1:0]  DO,
    output logic             DOVALID,
    output logic             EMPTY,
    output logic             ALMOSTEMPTY,
    output logic             RDERR,
    output logic [CNT_W-1:0] COUNT
);

    wr_ptr_t          wr_ptr;
    rd_ptr_t          rd_ptr;
    logic [CNT_W-1:0] occ;
    logic             wr_acc;
    logic             rd_acc;
    logic             vld_p1;

    // Occupancy in dibits; pointers are registers, so flags never see WREN/RDEN.
    assign occ    = {wr_ptr, 2'b00} - rd_ptr;
    assign EMPTY  = (occ == '0);
    assign FULL   = (occ > FULL_LEVEL);
    assign wr_acc = WREN && !FULL && !RST;
    assign rd_acc = RDEN && !EMPTY && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            WRERR  <= 1'b0;
            RDERR  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + wr_ptr_t'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + rd_ptr_t'(1);
            WRERR  <= WREN && FULL;
            RDERR  <= RDEN && EMPTY;
            vld_p1 <= rd_acc;
        end
    end

    x_fifo_s8_s2_mem u_mem (
        .clk      (CLK),
        .rst      (RST),
        .we       (wr_acc),
        .waddr    (wr_ptr[WR_AW-1:0]),
        .wdata    (DI),
        .re       (rd_acc),
        .raddr    (rd_ptr[RD_AW-1:0]),
        .rdata_p1 (DO)
    );

    assign DOVALID = vld_p1;

`ifdef X_FIFO_S8_S2_COUNT_EN
    logic [CNT_W-1:0] free_slots;

    assign free_slots  = RD_DEPTH - occ;
    assign COUNT       = occ;
    assign ALMOSTFULL  = (free_slots <= ALMOST_FULL_OFFSET);
    assign ALMOSTEMPTY = (occ <= ALMOST_EMPTY_OFFSET);
`else
    logic unused_cfg;

    assign unused_cfg  = ^{ALMOST_FULL_OFFSET, ALMOST_EMPTY_OFFSET};
    assign COUNT       = '0;
    assign ALMOSTFULL  = 1'b0;
    assign ALMOSTEMPTY = 1'b0;
`endif

endmodule
